// File: rtl/fdiv_pkg.sv
// Shared constants for the programmable frequency divider family.
package fdiv_pkg;

  // Default counter / reload width
  localparam int unsigned FDIV_WIDTH_DEF = 8;

  // Count direction encodings for up_dn
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/fdiv_terminal_detect.sv
// Terminal-count detector: flags the last count before wrap in the
// current direction. Purely combinational so a direction change is
// seen by the caller in the same cycle.
module fdiv_terminal_detect
  import fdiv_pkg::*;
#(
  parameter int unsigned WIDTH = FDIV_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up_dn,
  output logic             maxmin
);

  // All-ones when counting up, zero when counting down
  always_comb begin
    maxmin = 1'b0;
    if (up_dn == DIR_UP) begin
      maxmin = &q;
    end else begin
      maxmin = ~|q;
    end
  end

endmodule

// File: rtl/prog_freq_divider.sv
// Programmable frequency divider: loadable up/down counter with an
// auto-reload register, a registered terminal tick and a divided output.
// Optional feature macro FDIV_TOGGLE_OUT_EN: when defined, div_out is a
// toggle flop (50% duty, twice the tick period); otherwise div_out
// mirrors tick.
module prog_freq_divider
  import fdiv_pkg::*;
#(
  parameter int unsigned      WIDTH     = FDIV_WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock_oscillator,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             up_dn,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             maxmin,
  output logic             tick,
  output logic             div_out
);

  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] reload_next;
  logic             tick_next;
  logic [WIDTH-1:0] q_inc;
  logic [WIDTH-1:0] q_dec;
  logic [WIDTH-1:0] q_wrap;

  // Terminal detection on the live count and direction
  fdiv_terminal_detect #(
    .WIDTH (WIDTH)
  ) u_term (
    .q      (q),
    .up_dn  (up_dn),
    .maxmin (maxmin)
  );

  // Modulo-2^WIDTH neighbours and the free-wrap target
  always_comb begin
    q_inc  = q + WIDTH'(1);
    q_dec  = q - WIDTH'(1);
    q_wrap = (up_dn == DIR_UP) ? '0 : '1;
  end

  // Next-state selection: load beats terminal handling beats counting
  always_comb begin
    q_next      = q;
    reload_next = reload_reg;
    tick_next   = 1'b0;
    if (load) begin
      q_next      = din;
      reload_next = din;
    end else if (en) begin
      if (maxmin) begin
        tick_next = 1'b1;
        q_next    = auto_reload ? reload_reg : q_wrap;
      end else begin
        q_next = (up_dn == DIR_UP) ? q_inc : q_dec;
      end
    end
  end

  // Counter, reload register and tick state
  always_ff @(posedge clock_oscillator or negedge rst_n) begin
    if (!rst_n) begin
      q          <= RESET_VAL;
      reload_reg <= '0;
      tick       <= 1'b0;
    end else begin
      q          <= q_next;
      reload_reg <= reload_next;
      tick       <= tick_next;
    end
  end

`ifdef FDIV_TOGGLE_OUT_EN
  // Toggle once per terminal event for a 50% duty divided clock
  always_ff @(posedge clock_oscillator or negedge rst_n) begin
    if (!rst_n) begin
      div_out <= 1'b0;
    end else if (tick_next) begin
      div_out <= ~div_out;
    end
  end
`else
  // Divided output is the terminal pulse itself
  assign div_out = tick;
`endif

endmodule

// File: tb/tb_prog_freq_divider.sv
// Self-checking bench for prog_freq_divider (WIDTH=8): directed scenarios
// with hand-computed expectations plus randomized traffic compared every
// cycle against a modular-arithmetic reference model.
module tb_prog_freq_divider;

  localparam int W    = 8;
  localparam int MOD  = 1 << W;
  localparam int MAXV = MOD - 1;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         load;
  logic [W-1:0] din;
  logic         up_dn;
  logic         auto_reload;
  logic [W-1:0] q;
  logic         maxmin;
  logic         tick;
  logic         div_out;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_q    = 0;
  int m_rl   = 0;
  bit m_tick = 1'b0;
  bit m_div  = 1'b0;

  prog_freq_divider #(
    .WIDTH     (W),
    .RESET_VAL (8'h00)
  ) dut (
    .clock_oscillator (clk),
    .rst_n            (rst_n),
    .en               (en),
    .load             (load),
    .din              (din),
    .up_dn            (up_dn),
    .auto_reload      (auto_reload),
    .q                (q),
    .maxmin           (maxmin),
    .tick             (tick),
    .div_out          (div_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counting is modular arithmetic, terminal is the
  // last value before wrapping in the current direction.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q    = 0;
      m_rl   = 0;
      m_tick = 1'b0;
      m_div  = 1'b0;
    end else begin
      int  step;
      bit  term;
      step = up_dn ? 1 : -1;
      term = up_dn ? (m_q == MAXV) : (m_q == 0);
      if (load) begin
        m_q    = int'(din);
        m_rl   = int'(din);
        m_tick = 1'b0;
      end else if (en) begin
        m_tick = term;
        if (term && auto_reload) m_q = m_rl;
        else                     m_q = (m_q + step + MOD) % MOD;
      end else begin
        m_tick = 1'b0;
      end
`ifdef FDIV_TOGGLE_OUT_EN
      if (m_tick) m_div = ~m_div;
`else
      m_div = m_tick;
`endif
    end
  end

  // Every-cycle comparison, away from the active edge
  always @(negedge clk) begin
    chk("model_q",      32'(q),       32'(m_q));
    chk("model_maxmin", 32'(maxmin),  32'(up_dn ? (m_q == MAXV) : (m_q == 0)));
    chk("model_tick",   32'(tick),    32'(m_tick));
    chk("model_div",    32'(div_out), 32'(m_div));
  end

  // Advance one edge; inputs may be changed on return
  task automatic next();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Advance until tick is sampled high (bounded)
  task automatic wait_tick(input int budget);
    int n;
    n = 0;
    while (!tick && n < budget) begin
      next();
      n++;
    end
    chk("wait_tick_bound", 32'(tick), 32'(1));
  endtask

  // Cycles until the next tick, starting just after a tick
  task automatic meas_tick(input int budget, output int n);
    n = 0;
    do begin
      next();
      n++;
    end while (!tick && n < budget);
  endtask

  task automatic do_load(input logic [W-1:0] v, input logic dir, input logic ar);
    load        = 1'b1;
    din         = v;
    up_dn       = dir;
    auto_reload = ar;
    en          = 1'b1;
    next();
    load = 1'b0;
  endtask

  initial begin
    int per;
    rst_n       = 1'b0;
    en          = 1'b1;
    load        = 1'b0;
    din         = 8'h00;
    up_dn       = 1'b1;
    auto_reload = 1'b1;

    // Reset holds everything while clocking
    for (int i = 0; i < 5; i++) begin
      next();
      chk("rst_q", 32'(q), 32'(0));
      chk("rst_tick", 32'(tick), 32'(0));
      chk("rst_div", 32'(div_out), 32'(0));
    end
    en    = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next();
      chk("hold_q", 32'(q), 32'(0));
    end

    // Up divide from 8F: 8F..FF then reload, period 256-143 = 113
    do_load(8'h8F, 1'b1, 1'b1);
    chk("up_load_q", 32'(q), 32'h8F);
    for (int i = 1; i <= 112; i++) begin
      next();
      chk("up_seq_q", 32'(q), 32'(8'h8F + i));
      chk("up_seq_tick", 32'(tick), 32'(0));
    end
    chk("up_maxmin_at_ff", 32'(maxmin), 32'(1));
    next();
    chk("up_reload_q", 32'(q), 32'h8F);
    chk("up_reload_tick", 32'(tick), 32'(1));
    meas_tick(400, per);
    chk("up_period", 32'(per), 32'd113);
`ifdef FDIV_TOGGLE_OUT_EN
    begin
      int  n;
      bit  prev;
      int  edges;
      n = 0; edges = 0; per = 0;
      prev = div_out;
      while (edges < 2 && n < 1000) begin
        next();
        n++;
        if (edges == 1) per++;
        if (div_out && !prev) edges++;
        prev = div_out;
      end
      chk("div_toggle_period", 32'(per), 32'd226);
    end
`endif

    // Down divide from 8F: period 143+1 = 144
    do_load(8'h8F, 1'b0, 1'b1);
    chk("dn_load_q", 32'(q), 32'h8F);
    next();
    chk("dn_first_q", 32'(q), 32'h8E);
    wait_tick(400);
    chk("dn_reload_q", 32'(q), 32'h8F);
    meas_tick(400, per);
    chk("dn_period", 32'(per), 32'd144);

    // Free wrap up from FE: FE, FF, 00 (tick), 01
    do_load(8'hFE, 1'b1, 1'b0);
    chk("wrap_q0", 32'(q), 32'hFE);
    chk("wrap_t0", 32'(tick), 32'(0));
    next();
    chk("wrap_q1", 32'(q), 32'hFF);
    chk("wrap_t1", 32'(tick), 32'(0));
    next();
    chk("wrap_q2", 32'(q), 32'h00);
    chk("wrap_t2", 32'(tick), 32'(1));
    next();
    chk("wrap_q3", 32'(q), 32'h01);
    chk("wrap_t3", 32'(tick), 32'(0));

    // Reload all-ones counting up: terminal every cycle
    do_load(8'hFF, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      next();
      chk("ff_tick_const", 32'(tick), 32'(1));
      chk("ff_q_const", 32'(q), 32'hFF);
    end

    // Load on a terminal cycle wins: no tick
    chk("lot_maxmin", 32'(maxmin), 32'(1));
    load = 1'b1;
    din  = 8'h40;
    next();
    load = 1'b0;
    chk("lot_q", 32'(q), 32'h40);
    chk("lot_tick", 32'(tick), 32'(0));

    // Enable low for 5 cycles stretches the period by exactly 5
    do_load(8'h8F, 1'b1, 1'b1);
    wait_tick(400);
    per = 0;
    do begin
      en = !(per >= 10 && per < 15);
      next();
      per++;
    end while (!tick && per < 400);
    en = 1'b1;
    chk("stretch_period", 32'(per), 32'd118);

    // Async reset between edges at q=A0
    do_load(8'h8F, 1'b1, 1'b1);
    for (int i = 0; i < 17; i++) next();
    chk("pre_rst_q", 32'(q), 32'hA0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_q", 32'(q), 32'(0));
    chk("async_rst_tick", 32'(tick), 32'(0));
    next();
    chk("async_hold_q", 32'(q), 32'(0));
    rst_n = 1'b1;
    do_load(8'h8F, 1'b1, 1'b1);
    wait_tick(400);
    meas_tick(400, per);
    chk("post_rst_period", 32'(per), 32'd113);

    // Randomized traffic, checked every cycle against the model
    for (int i = 0; i < 3000; i++) begin
      load = ($urandom_range(0, 24) == 0);
      en   = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 15) == 0) up_dn = ~up_dn;
      if ($urandom_range(0, 7) == 0) auto_reload = ~auto_reload;
      case ($urandom_range(0, 3))
        0:       din = 8'(MAXV - $urandom_range(0, 3));
        1:       din = 8'($urandom_range(0, 3));
        default: din = 8'($urandom);
      endcase
      if ($urandom_range(0, 299) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
      end
      next();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_freq_divider.md
Name: prog_freq_divider

Overview:
- Parametrised programmable frequency divider built around a loadable up/down binary counter with an auto-reload register.
- Successor to the fixed 8-bit cascaded divider. Adds:
  - generic width
  - count direction select
  - count enable
  - reload-on-terminal without external feedback
  - a registered divided-clock output
- Sits between the board oscillator and the synchronizer logic; supplies the slow tick/clock.

Parameters:
- WIDTH, 8, counter, load value and reload register width (≥2).
- RESET_VAL, 0, value of q after reset (WIDTH bits).

Ports:
- clock_oscillator  input   1  sole clock, rising-edge
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  count enable
- load  input  1  synchronous load of din into counter and reload register
- din  input  WIDTH  load value
- up_dn  input  1  1 = count up, 0 = count down
- auto_reload  input  1  1 = reload from reload register at terminal, 0 = free wrap
- q  output  WIDTH  current count
- maxmin  output  1  terminal indicator (combinational)
- tick  output  1  one-cycle registered terminal pulse
- div_out  output  1  divided output

Behaviour:
- Async reset (rst_n=0), all values hold while low:
  - q=RESET_VAL
  - reload_reg=0
  - tick=0
  - div_out=0
- maxmin is combinational from q and up_dn:
  - asserted when up_dn=1 and q=all-ones
  - asserted when up_dn=0 and q=0
- Per rising edge, in priority order:
  1. load=1: q<=din, reload_reg<=din, tick<=0. Ignores en.
  2. en=1 and maxmin=1 and auto_reload=1: q<=reload_reg, tick<=1.
  3. en=1 and maxmin=1 and auto_reload=0: q wraps (all-ones→0 up, 0→all-ones down), tick<=1.
  4. en=1 otherwise: q<=q+1 (up) or q−1 (down), tick<=0.
  5. en=0: q holds, tick<=0.
- Arithmetic is modulo 2^WIDTH; no carry out beyond tick.
- Divide period with auto_reload=1 and constant en=1, R = reload value:
  - up: 2^WIDTH − R cycles
  - down: R+1 cycles
- Boundary cases:
  - R = all-ones, up (or R=0, down): terminal every cycle; tick stays high continuously, period 1.
  - up_dn change mid-count: takes effect at the next edge; maxmin re-evaluates immediately with the new direction.
  - load coincident with terminal: load wins, no tick.
  - reset mid-count: immediate return to reset values; reload_reg is lost and must be reloaded.

Optional Feature:
- Macro: FDIV_TOGGLE_OUT_EN.
- Defined: div_out is a register that toggles on every edge where tick is set to 1.
  - Yields 50% duty, period 2× tick period.
  - Cleared by reset; unaffected by load.
- Undefined: div_out is tied to tick (one-cycle pulse per terminal).

Decomposition:
- Shared package/include fdiv_pkg:
  - DIR_UP=1'b1, DIR_DN=1'b0 constants
  - default WIDTH
- Natural sub-module: fdiv_terminal_detect.
  - Combinational maxmin from q and up_dn.
  - Reused by future cascaded/BCD variants.

Test Plan:
- Reset/hold: rst_n=0 while clocking → q=0, tick=0, div_out=0 throughout. Release rst_n with en=0 → q holds at 0.
- Up divide: WIDTH=8, load din=8'h8F, up_dn=1, auto_reload=1, en=1 → tick pulses every 113 cycles; q sequences 8F..FF then 8F. With FDIV_TOGGLE_OUT_EN, div_out period is 226 cycles.
- Down divide: load 8'h8F, up_dn=0, auto_reload=1 → tick every 144 cycles; q 8F..00 then 8F.
- Free wrap: load 8'hFE, up_dn=1, auto_reload=0 → q FE, FF, 00, 01; tick high only on the FF→00 edge.
- Edge cases:
  - load 8'hFF, up, auto_reload=1 → tick constantly 1.
  - assert load on a terminal cycle → no tick; q=din.
  - toggle en low 5 cycles mid-count → q frozen, period stretched by exactly 5.
- Async reset mid-count: drop rst_n between edges at q=8'hA0 → q=0 immediately (before next edge). After reload of 8'h8F, counting resumes correctly.
